ufm_writer: RTL and testbench

- Write-side counterpart of the UFM reader path.
- Accepts a byte stream (typically UART RX) and packs it into 16-byte pages.
- Programs each full page into UFM through the EFB Wishbone configuration interface, then polls busy until the page completes.
- Sits between the byte source and the ufm/EFB Wishbone slave. Pages must already be erased; this block never erases.

---
 rtl/ufm_writer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ufm_writer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufm_writer.sv
// ufm_writer: packs an incoming byte stream into 16-byte pages and programs
// each full page into UFM through the EFB Wishbone configuration port.
// Pages are assumed to be erased already; this block never erases.
//
// phase | meaning
// FILL  | accepting bytes into the page buffer
// EN    | enable-transparent frame
// ADDR  | set UFM page address frame
// PROG  | program-page frame carrying the 16 buffered bytes
// POLL  | status frame with a CFGRXDR read, repeated while UFM is busy
// DIS   | disable frame
// BYP   | bypass frame, then page_done (unless errored)
// HALT  | all pages written or poll timeout; idle until rst
module ufm_writer #(
    parameter int         START_PAGE = 2042,
    parameter int         NUM_PAGES  = 4,
    parameter logic [7:0] PAD_BYTE   = 8'h00,
    parameter int         POLL_LIMIT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic       busy,
    output logic       page_done,
    output logic       full,
    output logic       error,
    output logic       efb__cyc,
    output logic       efb__stb,
    output logic       efb__we,
    output logic [7:0] efb__adr,
    output logic [7:0] efb__dat_w,
    input  logic [7:0] efb__dat_r,
    input  logic       efb__ack
);
    typedef enum logic [2:0] {
        PH_FILL, PH_EN, PH_ADDR, PH_PROG, PH_POLL, PH_DIS, PH_BYP, PH_HALT
    } phase_t;

    localparam logic [7:0]  REG_CFGCR  = 8'h70;
    localparam logic [7:0]  REG_TXDR   = 8'h71;
    localparam logic [7:0]  REG_RXDR   = 8'h73;
    localparam logic [10:0] FIRST_PAGE = 11'(START_PAGE);
    localparam logic [10:0] LAST_PAGE  = 11'(START_PAGE + NUM_PAGES - 1);
    localparam logic [15:0] POLL_MAX   = 16'(POLL_LIMIT);

    phase_t      phase_q, phase_d;
    logic [4:0]  step_q, step_d;
    logic [3:0]  idx_q, idx_d;
    logic [10:0] page_q, page_d;
    logic [15:0] polls_q, polls_d;
    logic        rd_busy_q, rd_busy_d;
    logic [7:0]  page_buf_q [16];
    logic [7:0]  page_buf_d [16];
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        page_done_q, page_done_d;
    logic        full_q, full_d;
    logic        error_q, error_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [7:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;

    logic [4:0]  k;
    logic [4:0]  frame_len;
    logic [4:0]  last_step;
    logic [4:0]  pad_from;
    logic [3:0]  prog_idx;
    logic [7:0]  tx_byte;
    logic        accept;
    logic        unused_rd_bits;

    // Only the busy flag (bit 7) of the status byte matters.
    assign unused_rd_bits = ^efb__dat_r[6:0];
    assign accept         = in_valid && in_ready_q;

    // Frame content: TXDR byte for the current step and frame length.
    // Step 0 is CFGCR=0x80, steps 1..frame_len are TXDR bytes, POLL adds a
    // CFGRXDR read, and the last step is CFGCR=0x00.
    always_comb begin
        k         = step_q - 5'd1;
        prog_idx  = 4'(k - 5'd4);
        tx_byte   = 8'h00;
        frame_len = 5'd4;
        case (phase_q)
            PH_EN: begin
                if (k == 5'd0)      tx_byte = 8'h74;
                else if (k == 5'd1) tx_byte = 8'h08;
            end
            PH_ADDR: begin
                frame_len = 5'd8;
                case (k)
                    5'd0:    tx_byte = 8'hB4;
                    5'd4:    tx_byte = 8'h40;
                    5'd6:    tx_byte = {5'b0, page_q[10:8]};
                    5'd7:    tx_byte = page_q[7:0];
                    default: tx_byte = 8'h00;
                endcase
            end
            PH_PROG: begin
                frame_len = 5'd20;
                if (k == 5'd0)       tx_byte = 8'hC9;
                else if (k == 5'd3)  tx_byte = 8'h01;
                else if (k >= 5'd4)  tx_byte = page_buf_q[prog_idx];
            end
            PH_POLL: begin
                if (k == 5'd0) tx_byte = 8'hF0;
            end
            PH_DIS: begin
                frame_len = 5'd3;
                if (k == 5'd0) tx_byte = 8'h26;
            end
            PH_BYP:  tx_byte = 8'hFF;
            default: ;
        endcase
        last_step = frame_len + ((phase_q == PH_POLL) ? 5'd2 : 5'd1);
    end

    // Next-state logic: page filling, Wishbone handshaking and frame sequencing
    always_comb begin
        phase_d     = phase_q;
        step_d      = step_q;
        idx_d       = idx_q;
        page_d      = page_q;
        polls_d     = polls_q;
        rd_busy_d   = rd_busy_q;
        page_buf_d  = page_buf_q;
        page_done_d = 1'b0;
        full_d      = full_q;
        error_d     = error_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        pad_from    = {1'b0, idx_q};
        case (phase_q)
            PH_FILL: begin
                if (accept) begin
                    page_buf_d[idx_q] = in_data;
                    idx_d             = idx_q + 4'd1;
                    pad_from          = {1'b0, idx_q} + 5'd1;
                end
                // A byte taken together with flush is stored before padding.
                if ((accept && idx_q == 4'd15) || (flush && pad_from != 5'd0)) begin
                    for (int i = 0; i < 16; i++) begin
                        if (5'(i) >= pad_from) page_buf_d[i] = PAD_BYTE;
                    end
                    phase_d = PH_EN;
                    step_d  = 5'd0;
                    idx_d   = 4'd0;
                    polls_d = 16'd0;
                end
            end
            PH_HALT: ;
            default: begin
                if (cyc_q) begin
                    if (efb__ack) begin
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                        we_d  = 1'b0;
                        if (!we_q) rd_busy_d = efb__dat_r[7];
                        if (step_q == last_step) begin
                            step_d = 5'd0;
                            case (phase_q)
                                PH_EN:   phase_d = PH_ADDR;
                                PH_ADDR: phase_d = PH_PROG;
                                PH_PROG: phase_d = PH_POLL;
                                PH_POLL: begin
                                    if (!rd_busy_q) begin
                                        phase_d = PH_DIS;
                                    end else if (polls_q + 16'd1 == POLL_MAX) begin
                                        error_d = 1'b1;
                                        phase_d = PH_DIS;
                                    end else begin
                                        polls_d = polls_q + 16'd1;
                                    end
                                end
                                PH_DIS:  phase_d = PH_BYP;
                                PH_BYP: begin
                                    idx_d = 4'd0;
                                    if (error_q) begin
                                        phase_d = PH_HALT;
                                    end else begin
                                        page_done_d = 1'b1;
                                        page_d      = page_q + 11'd1;
                                        if (page_q == LAST_PAGE) begin
                                            full_d  = 1'b1;
                                            phase_d = PH_HALT;
                                        end else begin
                                            phase_d = PH_FILL;
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            step_d = step_q + 5'd1;
                        end
                    end
                end else begin
                    // Idle cycle after the previous ack: launch the next transfer.
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                    if (step_q == 5'd0) begin
                        adr_d = REG_CFGCR;
                        dat_d = 8'h80;
                    end else if (step_q <= frame_len) begin
                        adr_d = REG_TXDR;
                        dat_d = tx_byte;
                    end else if (phase_q == PH_POLL && step_q == frame_len + 5'd1) begin
                        adr_d = REG_RXDR;
                        dat_d = 8'h00;
                        we_d  = 1'b0;
                    end else begin
                        adr_d = REG_CFGCR;
                        dat_d = 8'h00;
                    end
                end
            end
        endcase
        in_ready_d = (phase_d == PH_FILL);
        busy_d     = (phase_d != PH_FILL) && (phase_d != PH_HALT);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= PH_FILL;
            step_q      <= 5'd0;
            idx_q       <= 4'd0;
            page_q      <= FIRST_PAGE;
            polls_q     <= 16'd0;
            rd_busy_q   <= 1'b0;
            for (int i = 0; i < 16; i++) page_buf_q[i] <= PAD_BYTE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            page_done_q <= 1'b0;
            full_q      <= 1'b0;
            error_q     <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 8'h00;
            dat_q       <= 8'h00;
        end else begin
            phase_q     <= phase_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            page_q      <= page_d;
            polls_q     <= polls_d;
            rd_busy_q   <= rd_busy_d;
            page_buf_q  <= page_buf_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            page_done_q <= page_done_d;
            full_q      <= full_d;
            error_q     <= error_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign page_done  = page_done_q;
    assign full       = full_q;
    assign error      = error_q;
    assign efb__cyc   = cyc_q;
    assign efb__stb   = stb_q;
    assign efb__we    = we_q;
    assign efb__adr   = adr_q;
    assign efb__dat_w = dat_q;
endmodule

// File: tb/tb_ufm_writer.sv
// tb_ufm_writer: random page data and EFB timing against a frame-level model
// of the UFM programming command stream.
module tb_ufm_writer;
    localparam int START  = 2042;
    localparam int NPAGES = 4;
    localparam int LIMIT  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic       busy, page_done, full, error;
    logic       efb__cyc, efb__stb, efb__we;
    logic [7:0] efb__adr, efb__dat_w;
    logic [7:0] efb__dat_r = 8'h00;
    logic       efb__ack = 1'b0;

    always #5 clk = ~clk;

    ufm_writer #(.START_PAGE(START), .NUM_PAGES(NPAGES), .PAD_BYTE(8'h00), .POLL_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .busy(busy), .page_done(page_done), .full(full), .error(error),
        .efb__cyc(efb__cyc), .efb__stb(efb__stb), .efb__we(efb__we), .efb__adr(efb__adr),
        .efb__dat_w(efb__dat_w), .efb__dat_r(efb__dat_r), .efb__ack(efb__ack)
    );

    int total = 0;
    int bad = 0;
    int ack_delay = 0;
    int wcnt = 0;
    int rd_cnt = 0;
    int busy_until = 0;
    bit stuck = 0;
    int done_cnt = 0;
    int done_exp = 0;
    int log_base = 0;
    int exp_page = START;
    logic [16:0] log_q[$];
    logic [16:0] exp_q[$];
    logic [7:0]  fr_q[$];
    logic [7:0]  pg_data[16];

    // EFB slave: acks after ack_delay extra cycles, logs every transfer,
    // reports UFM busy for reads before busy_until (or always when stuck).
    always @(negedge clk) begin
        if (rst) begin
            efb__ack = 1'b0;
            wcnt = 0;
        end else if (efb__ack) begin
            efb__ack = 1'b0;
            total++;
            if (efb__cyc !== 1'b0) begin
                bad++;
                $display("FAIL wb_drop cyc after ack got %b want 0", efb__cyc);
            end
        end else if (efb__cyc && efb__stb) begin
            if (wcnt >= ack_delay) begin
                wcnt = 0;
                efb__ack = 1'b1;
                if (efb__we) begin
                    log_q.push_back({1'b1, efb__adr, efb__dat_w});
                end else begin
                    log_q.push_back({1'b0, efb__adr, 8'h00});
                    efb__dat_r = {(stuck || rd_cnt < busy_until), 7'($urandom)};
                    rd_cnt++;
                end
            end else begin
                wcnt++;
            end
        end
    end

    always @(negedge clk) if (!rst && page_done) done_cnt++;

    task automatic add_bytes(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fr_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic emit_frame(input bit rd);
        exp_q.push_back({1'b1, 8'h70, 8'h80});
        foreach (fr_q[i]) exp_q.push_back({1'b1, 8'h71, fr_q[i]});
        if (rd) exp_q.push_back({1'b0, 8'h73, 8'h00});
        exp_q.push_back({1'b1, 8'h70, 8'h00});
        fr_q.delete();
    endtask

    // Expected command stream for one page holding pg_data.
    task automatic model_page(input int page, input int busy_polls);
        int frames;
        add_bytes(64'h74080000, 4); emit_frame(0);
        add_bytes({8'hB4, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'(page / 256), 8'(page % 256)}, 8);
        emit_frame(0);
        add_bytes(64'hC9000001, 4);
        for (int i = 0; i < 16; i++) fr_q.push_back(pg_data[i]);
        emit_frame(0);
        frames = (busy_polls >= LIMIT) ? LIMIT : busy_polls + 1;
        for (int f = 0; f < frames; f++) begin add_bytes(64'hF0000000, 4); emit_frame(1); end
        add_bytes(64'h260000, 3); emit_frame(0);
        add_bytes(64'hFFFFFFFF, 4); emit_frame(0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fl);
        int t = 0;
        in_data = b; in_valid = 1'b1; flush = fl;
        while (in_ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) begin
            total++; bad++;
            $display("FAIL send_byte in_ready timeout got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done_cnt < done_exp && cycles < 5000) begin @(negedge clk); cycles++; end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_log(input string nm);
        int n = log_q.size() - log_base;
        total++;
        if (n != exp_q.size()) begin
            bad++;
            $display("FAIL %s txn_count got %0d want %0d", nm, n, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            total++;
            if (log_q[log_base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s txn[%0d] got we=%b adr=%h dat=%h want we=%b adr=%h dat=%h", nm, i,
                         log_q[log_base + i][16], log_q[log_base + i][15:8], log_q[log_base + i][7:0],
                         exp_q[i][16], exp_q[i][15:8], exp_q[i][7:0]);
            end
        end
        log_base = log_q.size();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        log_base = log_q.size();
        exp_page = START;
        stuck = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, busy, page_done, full, error, efb__cyc, efb__stb, efb__we} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_flags got %b want 10000000",
                     {in_ready, busy, page_done, full, error, efb__cyc, efb__stb, efb__we});
        end
        total++;
        if ({efb__adr, efb__dat_w} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_bus got adr=%h dat=%h want 00 00", efb__adr, efb__dat_w);
        end
        rst = 1'b0;
        @(negedge clk);
        log_base = log_q.size();
    endtask

    task automatic test_single_page();
        int cyc;
        ack_delay = 0; busy_until = rd_cnt;
        for (int i = 0; i < 16; i++) pg_data[i] = 8'(i);
        model_page(exp_page, 0);
        for (int i = 0; i < 16; i++) send_byte(pg_data[i], 1'b0);
        done_exp++;
        wait_done(cyc);
        $display("single page latency %0d cycles", cyc);
        total++;
        if (done_cnt !== done_exp) begin
            bad++; $display("FAIL single page_done got %0d want %0d", done_cnt, done_exp);
        end
        total++;
        if ({in_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL single idle got in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        check_log("single");
        exp_page++;
    endtask

    task automatic test_flush_partial();
        int cyc;
        ack_delay = 0; busy_until = rd_cnt;
        for (int i = 0; i < 16; i++) pg_data[i] = (i < 5) ? 8'(8'hA0 + i) : 8'h00;
        model_page(exp_page, 0);
        for (int i = 0; i < 5; i++) send_byte(pg_data[i], 1'b0);
        pulse_flush();
        done_exp++;
        wait_done(cyc);
        total++;
        if (done_cnt !== done_exp) begin
            bad++; $display("FAIL flush page_done got %0d want %0d", done_cnt, done_exp);
        end
        check_log("flush_partial");
        exp_page++;
        pulse_flush();
        repeat (30) @(negedge clk);
        total++;
        if ({busy, in_ready} !== 2'b01 || done_cnt !== done_exp) begin
            bad++; $display("FAIL flush_empty got busy=%b in_ready=%b done=%0d want 0 1 %0d",
                            busy, in_ready, done_cnt, done_exp);
        end
        check_log("flush_empty");
    endtask

    task automatic test_flush_accept();
        int cyc;
        int n = $urandom_range(1, 15);
        ack_delay = $urandom_range(0, 2); busy_until = rd_cnt;
        for (int i = 0; i < 16; i++) pg_data[i] = (i < n) ? 8'($urandom) : 8'h00;
        model_page(exp_page, 0);
        for (int i = 0; i < n; i++) send_byte(pg_data[i], (i == n - 1));
        done_exp++;
        wait_done(cyc);
        total++;
        if (done_cnt !== done_exp) begin
            bad++; $display("FAIL flush_accept page_done got %0d want %0d", done_cnt, done_exp);
        end
        check_log("flush_accept");
        exp_page++;
    endtask

    task automatic test_busy_polls();
        int cyc;
        ack_delay = 0; busy_until = rd_cnt + 3;
        for (int i = 0; i < 16; i++) pg_data[i] = 8'($urandom);
        model_page(exp_page, 3);
        for (int i = 0; i < 16; i++) send_byte(pg_data[i], 1'b0);
        done_exp++;
        wait_done(cyc);
        total++;
        if (done_cnt !== done_exp) begin
            bad++; $display("FAIL busy_polls page_done got %0d want %0d", done_cnt, done_exp);
        end
        check_log("busy_polls");
        exp_page++;
        total++;
        if ({full, in_ready, error} !== 3'b100) begin
            bad++; $display("FAIL last_page got full=%b in_ready=%b error=%b want 1 0 0", full, in_ready, error);
        end
    endtask

    task automatic test_poll_limit();
        int t = 0;
        do_reset();
        ack_delay = 0; stuck = 1;
        for (int i = 0; i < 16; i++) pg_data[i] = 8'($urandom);
        model_page(exp_page, 1000);
        for (int i = 0; i < 16; i++) send_byte(pg_data[i], 1'b0);
        while (!(error === 1'b1 && busy === 1'b0) && t < 5000) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        total++;
        if ({error, in_ready, busy, full} !== 4'b1000) begin
            bad++; $display("FAIL poll_limit got error=%b in_ready=%b busy=%b full=%b want 1 0 0 0",
                            error, in_ready, busy, full);
        end
        total++;
        if (done_cnt !== done_exp) begin
            bad++; $display("FAIL poll_limit page_done got %0d want %0d", done_cnt, done_exp);
        end
        check_log("poll_limit");
        stuck = 0;
    endtask

    task automatic test_full();
        int cyc;
        bit saw_ready = 0;
        do_reset();
        ack_delay = $urandom_range(0, 2);
        for (int p = 0; p < NPAGES; p++) begin
            int nb = $urandom_range(0, LIMIT - 1);
            busy_until = rd_cnt + nb;
            for (int i = 0; i < 16; i++) pg_data[i] = 8'($urandom);
            model_page(exp_page, nb);
            for (int i = 0; i < 16; i++) send_byte(pg_data[i], 1'b0);
            done_exp++;
            wait_done(cyc);
            exp_page++;
        end
        total++;
        if (done_cnt !== done_exp) begin
            bad++; $display("FAIL full page_done got %0d want %0d", done_cnt, done_exp);
        end
        check_log("full_pages");
        in_data = 8'h5A; in_valid = 1'b1;
        repeat (20) begin @(negedge clk); if (in_ready !== 1'b0) saw_ready = 1; end
        in_valid = 1'b0;
        total++;
        if (saw_ready || full !== 1'b1) begin
            bad++; $display("FAIL byte65 got in_ready_seen=%b full=%b want 0 1", saw_ready, full);
        end
        check_log("byte65");
    endtask

    task automatic test_reset_mid_prog();
        int t = 0;
        int cyc;
        do_reset();
        ack_delay = 3; busy_until = rd_cnt;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        while (!(log_q.size() - log_base >= 20 && efb__cyc === 1'b1) && t < 5000) begin
            @(negedge clk); t++;
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, busy, page_done, full, error, efb__cyc, efb__stb, efb__we} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL midreset_flags got %b want 10000000",
                     {in_ready, busy, page_done, full, error, efb__cyc, efb__stb, efb__we});
        end
        total++;
        if ({efb__adr, efb__dat_w} !== 16'h0000) begin
            bad++; $display("FAIL midreset_bus got adr=%h dat=%h want 00 00", efb__adr, efb__dat_w);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        log_base = log_q.size();
        exp_page = START;
        ack_delay = 0; busy_until = rd_cnt;
        for (int i = 0; i < 16; i++) pg_data[i] = 8'($urandom);
        model_page(exp_page, 0);
        for (int i = 0; i < 16; i++) send_byte(pg_data[i], 1'b0);
        done_exp++;
        wait_done(cyc);
        total++;
        if (done_cnt !== done_exp) begin
            bad++; $display("FAIL midreset page_done got %0d want %0d", done_cnt, done_exp);
        end
        check_log("midreset_restart");
    endtask

    initial begin
        test_reset();
        test_single_page();
        test_flush_partial();
        test_flush_accept();
        test_busy_polls();
        test_poll_limit();
        test_full();
        test_reset_mid_prog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
